// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C driver between N_REQ clients.
// Latches the winning client's payload, launches the driver, tracks its busy
// flag, returns read data with a per-client done pulse and aborts hung
// transfers with a watchdog.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req/req_rw        per-client request level and direction (1 = read)
//   req_addr          per-client 7-bit slave address, client i at [7i+6:7i]
//   req_wdata         per-client write byte, client i at [8i+7:8i]
//   gnt/done/err      one-hot grant, one-cycle done pulse, timeout flag
//   rdata             read byte, valid with done, held until the next done
//   drv_*             driver handshake (start/rw/addr/wdata out, rdata/busy in)
module i2c_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned START_TO = 16,
    parameter int unsigned XFER_TO  = 16384,
    parameter int unsigned TO_W     = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [7:0]           rdata,
    output logic                 drv_start,
    output logic                 drv_rw,
    output logic [6:0]           drv_addr,
    output logic [7:0]           drv_wdata,
    input  logic [7:0]           drv_rdata,
    input  logic                 drv_busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [TO_W-1:0]      cnt_q;
    logic [N_REQ-1:0]     gnt_q;
    logic [N_REQ-1:0]     done_q;
    logic                 err_q;
    logic [7:0]           rdata_q;
    logic                 drv_start_q;
    logic                 drv_rw_q;
    logic [6:0]           drv_addr_q;
    logic [7:0]           drv_wdata_q;

    logic [2*N_REQ-1:0]   req2_d;
    logic [N_REQ-1:0]     rot_d;
    logic                 pick_vld_d;
    logic [IDX_W-1:0]     off_d;
    logic [SUM_W-1:0]     sum_d;
    logic [IDX_W-1:0]     pick_idx_d;
    logic [IDX_W-1:0]     rr_nxt_d;
    logic                 sel_rw_d;
    logic [6:0]           sel_addr_d;
    logic [7:0]           sel_wdata_d;

    // Round-robin pick: rotate req so rr_ptr sits at bit 0, take the lowest
    // set bit, then rotate the offset back into a client index.
    always_comb begin
        req2_d     = {req, req};
        rot_d      = N_REQ'(req2_d >> rr_ptr_q);
        pick_vld_d = |rot_d;
        off_d      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_d[k]) off_d = IDX_W'(k);
        end
        sum_d = SUM_W'(rr_ptr_q) + SUM_W'(off_d);
        if (sum_d >= SUM_W'(N_REQ)) sum_d = sum_d - SUM_W'(N_REQ);
        pick_idx_d = IDX_W'(sum_d);
        rr_nxt_d   = (pick_idx_d == IDX_W'(N_REQ - 1)) ? '0 : pick_idx_d + IDX_W'(1);
    end

    // Payload mux for the winning client.
    always_comb begin
        sel_rw_d    = 1'b0;
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx_d == IDX_W'(i)) begin
                sel_rw_d    = req_rw[i];
                sel_addr_d  = req_addr[7*i +: 7];
                sel_wdata_d = req_wdata[8*i +: 8];
            end
        end
    end

    // Sequencer: done/err are single-cycle pulses raised on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            drv_start_q <= 1'b0;
            drv_rw_q    <= 1'b0;
            drv_addr_q  <= '0;
            drv_wdata_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A driver still busy from an aborted transfer blocks new launches.
                    if (pick_vld_d && !drv_busy) begin
                        gnt_q       <= N_REQ'(1) << pick_idx_d;
                        rr_ptr_q    <= rr_nxt_d;
                        drv_rw_q    <= sel_rw_d;
                        drv_addr_q  <= sel_addr_d;
                        drv_wdata_q <= sel_wdata_d;
                        cnt_q       <= '0;
                        state_q     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (drv_busy) begin
                        drv_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_WAIT;
                    end else if (cnt_q >= TO_W'(START_TO)) begin
                        drv_start_q <= 1'b0;
                        done_q      <= gnt_q;
                        err_q       <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        drv_start_q <= 1'b1;
                        cnt_q       <= cnt_q + TO_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!drv_busy) begin
                        rdata_q <= drv_rdata;
                        done_q  <= gnt_q;
                        state_q <= ST_RESP;
                    end else if (cnt_q >= TO_W'(XFER_TO)) begin
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q       <= '0;
                    drv_start_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign drv_start = drv_start_q;
    assign drv_rw    = drv_rw_q;
    assign drv_addr  = drv_addr_q;
    assign drv_wdata = drv_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: the driver side is played by hand from
// the stimulus sequence; every check is an immediate assertion.
module tb_i2c_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   req_rw;
    logic [27:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic         err;
    logic [7:0]   rdata;
    logic         drv_start;
    logic         drv_rw;
    logic [6:0]   drv_addr;
    logic [7:0]   drv_wdata;
    logic [7:0]   drv_rdata;
    logic         drv_busy;

    int ntests = 0;
    int nfail  = 0;

    i2c_bus_arbiter #(
        .N_REQ(4), .START_TO(16), .XFER_TO(16384), .TO_W(15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .drv_start (drv_start),
        .drv_rw    (drv_rw),
        .drv_addr  (drv_addr),
        .drv_wdata (drv_wdata),
        .drv_rdata (drv_rdata),
        .drv_busy  (drv_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req      = 4'b0000;
        drv_busy = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Bounded wait for a grant, then check which client won.
    task automatic wait_gnt(input string tag, input logic [3:0] exp_gnt);
        int n = 0;
        while (gnt === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(gnt), 32'(exp_gnt));
    endtask

    // One complete transfer with the bench acting as a well-behaved driver.
    task automatic run_xfer(input string tag, input logic [3:0] exp_gnt, input logic exp_rw,
                            input logic [6:0] exp_addr, input logic [7:0] exp_wd,
                            input logic [7:0] ret, input int hold, input logic [3:0] clr);
        wait_gnt({tag, "_gnt"}, exp_gnt);
        chk({tag, "_rw"},    32'(drv_rw),    32'(exp_rw));
        chk({tag, "_addr"},  32'(drv_addr),  32'(exp_addr));
        chk({tag, "_wdata"}, 32'(drv_wdata), 32'(exp_wd));
        chk({tag, "_start0"}, 32'(drv_start), 32'd0);
        tick();
        chk({tag, "_start1"}, 32'(drv_start), 32'd1);
        drv_busy = 1'b1;
        tick();
        chk({tag, "_startoff"}, 32'(drv_start), 32'd0);
        repeat (hold) tick();
        chk({tag, "_nodone"}, 32'(done), 32'd0);
        drv_rdata = ret;
        drv_busy  = 1'b0;
        tick();
        chk({tag, "_done"},  32'(done), 32'(exp_gnt));
        chk({tag, "_err"},   32'(err),  32'd0);
        chk({tag, "_gntr"},  32'(gnt),  32'(exp_gnt));
        if (exp_rw) chk({tag, "_rdata"}, 32'(rdata), 32'(ret));
        req = req & ~clr;
        tick();
        chk({tag, "_done0"}, 32'(done), 32'd0);
        chk({tag, "_gnt0"},  32'(gnt),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        req_rw    = 4'b0000;
        req_addr  = '0;
        req_wdata = '0;
        drv_rdata = 8'h00;
        drv_busy  = 1'b0;
        tick();
        tick();
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_rdata", 32'(rdata),     32'd0);
        chk("rst_start", 32'(drv_start), 32'd0);
        chk("rst_addr",  32'(drv_addr),  32'd0);
        chk("rst_wdata", 32'(drv_wdata), 32'd0);
        rst = 1'b0;
        tick();

        // 1. Write from client 1
        req_addr  = {7'h00, 7'h00, 7'h50, 7'h00};
        req_wdata = {8'h00, 8'h00, 8'hA5, 8'h00};
        req_rw    = 4'b0000;
        req       = 4'b0010;
        run_xfer("wr", 4'b0010, 1'b0, 7'h50, 8'hA5, 8'h99, 2, 4'b0010);

        // 2. Read from client 0; rdata held after req drops
        req_addr  = {7'h00, 7'h00, 7'h00, 7'h21};
        req_wdata = {8'h00, 8'h00, 8'h00, 8'h5A};
        req_rw    = 4'b0001;
        req       = 4'b0001;
        run_xfer("rd", 4'b0001, 1'b1, 7'h21, 8'h5A, 8'h3C, 1, 4'b0001);
        drv_rdata = 8'hFF;
        tick();
        tick();
        chk("rd_hold", 32'(rdata), 32'h3C);

        // 3. Contention right after reset: grants 0,1,2,3
        do_reset();
        req_addr  = {7'h13, 7'h12, 7'h11, 7'h10};
        req_wdata = {8'h83, 8'h82, 8'h81, 8'h80};
        req_rw    = 4'b0000;
        req       = 4'b1111;
        run_xfer("ct0", 4'b0001, 1'b0, 7'h10, 8'h80, 8'h00, 1, 4'b0001);
        run_xfer("ct1", 4'b0010, 1'b0, 7'h11, 8'h81, 8'h00, 1, 4'b0010);
        run_xfer("ct2", 4'b0100, 1'b0, 7'h12, 8'h82, 8'h00, 1, 4'b0100);
        run_xfer("ct3", 4'b1000, 1'b0, 7'h13, 8'h83, 8'h00, 1, 4'b1000);
        repeat (4) tick();
        chk("ct_idle_gnt",  32'(gnt),  32'd0);
        chk("ct_idle_done", 32'(done), 32'd0);

        // 4. Fairness: req0 held, req2 pulsed -> 0,2,0,2
        do_reset();
        req = 4'b0101;
        run_xfer("fa0", 4'b0001, 1'b0, 7'h10, 8'h80, 8'h00, 1, 4'b0000);
        run_xfer("fa1", 4'b0100, 1'b0, 7'h12, 8'h82, 8'h00, 1, 4'b0100);
        req[2] = 1'b1;
        run_xfer("fa2", 4'b0001, 1'b0, 7'h10, 8'h80, 8'h00, 1, 4'b0000);
        run_xfer("fa3", 4'b0100, 1'b0, 7'h12, 8'h82, 8'h00, 1, 4'b0100);
        req = 4'b0000;
        tick();
        tick();

        // 5. Start timeout: driver never answers
        req = 4'b1000;
        wait_gnt("sto_gnt", 4'b1000);
        tick();
        chk("sto_start1", 32'(drv_start), 32'd1);
        repeat (15) tick();
        chk("sto_start15", 32'(drv_start), 32'd1);
        chk("sto_nodone",  32'(done),      32'd0);
        tick();
        chk("sto_start0", 32'(drv_start), 32'd0);
        chk("sto_done",   32'(done),      32'b1000);
        chk("sto_err",    32'(err),       32'd1);
        chk("sto_gntr",   32'(gnt),       32'b1000);
        req = 4'b0000;
        tick();
        chk("sto_done0", 32'(done), 32'd0);
        chk("sto_err0",  32'(err),  32'd0);
        chk("sto_gnt0",  32'(gnt),  32'd0);

        // 6. Transfer timeout: busy never falls
        req = 4'b0001;
        wait_gnt("xto_gnt", 4'b0001);
        tick();
        drv_busy = 1'b1;
        tick();
        repeat (16384) tick();
        chk("xto_nodone", 32'(done), 32'd0);
        tick();
        chk("xto_done", 32'(done), 32'b0001);
        chk("xto_err",  32'(err),  32'd1);
        req = 4'b0000;
        tick();
        chk("xto_gnt0", 32'(gnt), 32'd0);

        // 7. Driver still busy after the abort: no launch until it clears
        req = 4'b0100;
        repeat (3) tick();
        chk("busy_block", 32'(gnt), 32'd0);
        drv_busy = 1'b0;
        run_xfer("busy_rel", 4'b0100, 1'b0, 7'h12, 8'h82, 8'h00, 1, 4'b0100);

        // 8. Reset in WAIT
        req = 4'b0010;
        wait_gnt("mr_gnt", 4'b0010);
        tick();
        drv_busy = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mr_gnt0",   32'(gnt),       32'd0);
        chk("mr_done0",  32'(done),      32'd0);
        chk("mr_start0", 32'(drv_start), 32'd0);
        chk("mr_addr0",  32'(drv_addr),  32'd0);
        drv_busy = 1'b0;
        req      = 4'b0100;
        tick();
        rst = 1'b0;
        run_xfer("mr_after", 4'b0100, 1'b0, 7'h12, 8'h82, 8'h00, 1, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
